// File: rtl/ballot_input.sv
// Ballot capture: synchronise and debounce three active-low buttons, then issue one
// active-low vote strobe per armed voter. Optional ARMED timeout under BALLOT_TIMEOUT_EN.
module ballot_input #(
  parameter int DEB_CYCLES     = 4,
  parameter int LOCK_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a_n,
  input  logic       btn_b_n,
  input  logic       btn_c_n,
  input  logic       voter_ok,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       armed,
  output logic       busy,
  output logic       err_multi,
  output logic [6:0] vote_cnt,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE, ARMED, ISSUE, HOLD} state_t;

  localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255 || LOCK_CYCLES < 1 || LOCK_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ballot_input: parameter out of legal range");
  end

  state_t     state;
  logic [2:0] raw, sync1, sync2, db, db_d, press;
  logic [7:0] deb_cnt [3];
  logic [7:0] lock_cnt;
  logic [1:0] n_high;
  logic       multi, single, need_release;

  // bit 0 = a, bit 1 = b, bit 2 = c; 1 = pressed from here on
  assign raw    = ~{btn_c_n, btn_b_n, btn_a_n};
  assign press  = db & ~db_d;
  assign n_high = {1'b0, db[0]} + {1'b0, db[1]} + {1'b0, db[2]};
  assign multi  = (press != 3'b000) && (n_high >= 2'd2);
  assign single = (press != 3'b000) && (n_high == 2'd1);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      // Level flips only after DEB_CYCLES consecutive disagreeing samples
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_cnt[i] <= '0;
          db[i]      <= ~db[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 8'd1;
        end
      end
    end
  end

`ifdef BALLOT_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT_CYCLES - 1);
  logic [DW-1:0] dwell;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      a            <= 1'b1;
      b            <= 1'b1;
      c            <= 1'b1;
      armed        <= 1'b0;
      busy         <= 1'b0;
      err_multi    <= 1'b0;
      vote_cnt     <= '0;
      need_release <= 1'b0;
      lock_cnt     <= '0;
`ifdef BALLOT_TIMEOUT_EN
      timeout      <= 1'b0;
      dwell        <= '0;
`endif
    end else begin
      a         <= 1'b1;
      b         <= 1'b1;
      c         <= 1'b1;
      err_multi <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (voter_ok && db == 3'b000) begin
            state        <= ARMED;
            armed        <= 1'b1;
            need_release <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            dwell        <= '0;
`endif
          end
        end
        ARMED: begin
`ifdef BALLOT_TIMEOUT_EN
          dwell <= dwell + 1'b1;
          if (dwell == DWELL_LAST) begin
            state   <= IDLE;
            armed   <= 1'b0;
            timeout <= 1'b1;
          end else
`endif
          if (multi) begin
            err_multi    <= 1'b1;
            need_release <= 1'b1;
          end else if (single && !need_release) begin
            state <= ISSUE;
            armed <= 1'b0;
            busy  <= 1'b1;
            {c, b, a} <= ~press;
            if (vote_cnt != 7'd127) vote_cnt <= vote_cnt + 7'd1;
          end else if (db == 3'b000) begin
            need_release <= 1'b0;
          end
        end
        ISSUE: begin
          state    <= HOLD;
          lock_cnt <= '0;
        end
        HOLD: begin
          // Hold-off counts only fully released cycles; any press restarts it
          if (db != 3'b000) begin
            lock_cnt <= '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_input.sv
// Bench for ballot_input: scenario table, hand-written corner sequences and random
// stimulus, all checked every cycle against a history-based reference model.
module tb_ballot_input;

  localparam int DEB  = 4;
  localparam int LOCK = 8;
  localparam int TMO  = 50;
  localparam int P_IDLE = 0, P_ARMED = 1, P_ISSUE = 2, P_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst, btn_a_n, btn_b_n, btn_c_n, voter_ok;
  logic       a, b, c, armed, busy, err_multi, timeout;
  logic [6:0] vote_cnt;
  logic [1:0] state_dbg;

  ballot_input #(.DEB_CYCLES(DEB), .LOCK_CYCLES(LOCK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .btn_a_n(btn_a_n), .btn_b_n(btn_b_n), .btn_c_n(btn_c_n),
    .voter_ok(voter_ok), .a(a), .b(b), .c(c), .armed(armed), .busy(busy),
    .err_multi(err_multi), .vote_cnt(vote_cnt), .timeout(timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tally_a = 0, tally_b = 0, tally_c = 0, tally_err = 0, tally_tmo = 0;

  // Reference model: raw/sync sample histories, debounced levels, phase of the ballot
  logic [2:0]  raw_hist[$];
  logic [2:0]  sync_hist[$];
  logic [13:0] exp_q[$];
  logic [2:0]  m_db = '0, m_db_prev = '0;
  int          m_phase = P_IDLE, m_quiet = 0, m_dwell = 0, m_cnt = 0;
  bit          m_blocked = 0;
  bit          m_a = 1, m_b = 1, m_c = 1, m_armed = 0, m_busy = 0, m_err = 0, m_tmo = 0;

  function automatic logic [13:0] model_vec();
    return {m_a, m_b, m_c, m_armed, m_busy, m_err, m_tmo, 7'(m_cnt)};
  endfunction

  function automatic int ones(input logic [2:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]);
  endfunction

  task automatic model_edge(input logic [2:0] raw, input bit vok, input bit r);
    logic [2:0] sync_seen, new_db, rises, t;
    bit all_diff, timed_out;
    if (r) begin
      raw_hist.delete(); sync_hist.delete();
      m_db = '0; m_db_prev = '0; m_phase = P_IDLE; m_blocked = 0; m_quiet = 0; m_dwell = 0;
      m_a = 1; m_b = 1; m_c = 1; m_armed = 0; m_busy = 0; m_err = 0; m_tmo = 0; m_cnt = 0;
      exp_q.push_back(model_vec());
      return;
    end
    // The debouncer sees the raw level from two edges ago
    sync_seen = (raw_hist.size() >= 2) ? raw_hist[1] : 3'b000;
    sync_hist.push_front(sync_seen);
    if (sync_hist.size() > DEB) void'(sync_hist.pop_back());
    new_db = m_db;
    for (int i = 0; i < 3; i++) begin
      if (sync_hist.size() == DEB) begin
        all_diff = 1;
        for (int k = 0; k < DEB; k++) begin
          t = sync_hist[k];
          if (t[i] == m_db[i]) all_diff = 0;
        end
        if (all_diff) new_db[i] = ~m_db[i];
      end
    end
    rises = m_db & ~m_db_prev;
    m_a = 1; m_b = 1; m_c = 1; m_err = 0; m_tmo = 0;
    case (m_phase)
      P_IDLE: if (vok && m_db == 3'b000) begin
        m_phase = P_ARMED; m_armed = 1; m_blocked = 0; m_dwell = 0;
      end
      P_ARMED: begin
        timed_out = 0;
`ifdef BALLOT_TIMEOUT_EN
        m_dwell++;
        timed_out = (m_dwell == TMO);
`endif
        if (timed_out) begin
          m_phase = P_IDLE; m_armed = 0; m_tmo = 1;
        end else if (rises != 3'b000 && ones(m_db) > 1) begin
          m_err = 1; m_blocked = 1;
        end else if (rises != 3'b000 && ones(m_db) == 1 && !m_blocked) begin
          m_phase = P_ISSUE; m_armed = 0; m_busy = 1;
          m_a = ~rises[0]; m_b = ~rises[1]; m_c = ~rises[2];
          if (m_cnt < 127) m_cnt++;
        end else if (m_db == 3'b000) begin
          m_blocked = 0;
        end
      end
      P_ISSUE: begin m_phase = P_HOLD; m_quiet = 0; end
      default: begin
        if (m_db != 3'b000) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == LOCK) begin m_phase = P_IDLE; m_busy = 0; end
        end
      end
    endcase
    raw_hist.push_front(raw);
    if (raw_hist.size() > 2) void'(raw_hist.pop_back());
    m_db_prev = m_db;
    m_db = new_db;
    exp_q.push_back(model_vec());
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Drive one cycle (press bits: 0=a 1=b 2=c), advance model, compare all outputs
  task automatic step(input logic [2:0] press, input bit vok, input bit r);
    logic [13:0] act, exp;
    btn_a_n = ~press[0]; btn_b_n = ~press[1]; btn_c_n = ~press[2];
    voter_ok = vok; rst = r;
    @(posedge clk);
    model_edge(press, vok, r);
    #1;
    act = {a, b, c, armed, busy, err_multi, timeout, vote_cnt};
    exp = exp_q.pop_front();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL cycle_outputs t=%0t got=%b want=%b", $time, act, exp);
    end
    if (a === 1'b0) tally_a++;
    if (b === 1'b0) tally_b++;
    if (c === 1'b0) tally_c++;
    if (err_multi === 1'b1) tally_err++;
    if (timeout === 1'b1) tally_tmo++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 0, 0);
  endtask

  task automatic hold_n(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) step(p, 0, 0);
  endtask

  typedef struct {
    bit         arm;
    logic [2:0] press;
    int         hold;
    int         rel;
    int         exp_a, exp_b, exp_c, exp_err;
  } row_t;

  row_t rows[8];

  initial begin
    int ta, tb, tc, te, strobe_at;
    logic [2:0] p;
    int dur;
    bit vok;

    rows[0] = '{1, 3'b010, 20, 25, 0, 1, 0, 0};  // armed b vote
    rows[1] = '{0, 3'b010, 20, 25, 0, 0, 0, 0};  // no re-arm, no vote
    rows[2] = '{1, 3'b101, 10, 10, 0, 0, 0, 1};  // a+c together
    rows[3] = '{0, 3'b100, 10, 25, 0, 0, 1, 0};  // c alone after release
    rows[4] = '{1, 3'b111, 10, 10, 0, 0, 0, 1};  // all three
    rows[5] = '{0, 3'b001,  3, 10, 0, 0, 0, 0};  // glitch shorter than DEB
    rows[6] = '{0, 3'b001, 10, 25, 1, 0, 0, 0};  // clean a
    rows[7] = '{1, 3'b000, 10,  5, 0, 0, 0, 0};  // arm, nothing pressed

    // Clock/reset
    step(3'b000, 0, 1);
    step(3'b000, 0, 1);
    check_val("reset_outputs", int'({a, b, c, armed, busy, err_multi, timeout, vote_cnt}),
              int'(14'b11100000000000));
    check_val("reset_state", int'(state_dbg), 0);

    // First vote: strobe must land exactly on edge 3+DEB after the press
    step(3'b000, 1, 0);
    check_val("armed_after_ok", int'(armed), 1);
    strobe_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step(3'b010, 0, 0);
      if (b === 1'b0 && strobe_at < 0) strobe_at = k;
    end
    check_val("b_strobe_edge", strobe_at, 3 + DEB);
    check_val("b_strobe_count", tally_b, 1);
    check_val("first_vote_cnt", int'(vote_cnt), 1);
    idle_n(25);

    // Table of scenarios
    for (int r = 0; r < 8; r++) begin
      ta = tally_a; tb = tally_b; tc = tally_c; te = tally_err;
      if (rows[r].arm) step(3'b000, 1, 0);
      hold_n(rows[r].press, rows[r].hold);
      idle_n(rows[r].rel);
      check_val($sformatf("row%0d_a", r), tally_a - ta, rows[r].exp_a);
      check_val($sformatf("row%0d_b", r), tally_b - tb, rows[r].exp_b);
      check_val($sformatf("row%0d_c", r), tally_c - tc, rows[r].exp_c);
      check_val($sformatf("row%0d_err", r), tally_err - te, rows[r].exp_err);
    end
    check_val("still_armed_no_press", int'(armed), 1);
    hold_n(3'b001, 10);
    idle_n(25);

    // Bouncing a: low 2, high 1, low 2, release -> nothing; then a clean press
    ta = tally_a;
    step(3'b000, 1, 0);
    hold_n(3'b001, 2); hold_n(3'b000, 1); hold_n(3'b001, 2);
    idle_n(12);
    check_val("bounce_no_strobe", tally_a - ta, 0);
    hold_n(3'b001, 10);
    idle_n(25);
    check_val("bounce_then_clean", tally_a - ta, 1);

    // 130 votes on a: strobes keep coming, count saturates
    ta = tally_a;
    for (int v = 0; v < 130; v++) begin
      step(3'b000, 1, 0);
      hold_n(3'b001, 8);
      idle_n(18);
    end
    check_val("sat_strobes", tally_a - ta, 130);
    check_val("sat_vote_cnt", int'(vote_cnt), 127);

    // Reset during HOLD with a still held
    step(3'b000, 1, 0);
    hold_n(3'b001, 10);
    check_val("in_hold_busy", int'(busy), 1);
    ta = tally_a;
    step(3'b001, 0, 1);
    check_val("rst_vote_cnt", int'(vote_cnt), 0);
    check_val("rst_strobe_high", int'(a), 1);
    hold_n(3'b001, 8);
    for (int i = 0; i < 6; i++) step(3'b001, 1, 0);
    check_val("held_no_arm", int'(armed), 0);
    check_val("held_no_strobe", tally_a - ta, 0);
    idle_n(15);
    step(3'b000, 1, 0);
    hold_n(3'b001, 10);
    idle_n(25);
    check_val("rearm_strobe", tally_a - ta, 1);
    check_val("rearm_vote_cnt", int'(vote_cnt), 1);

`ifdef BALLOT_TIMEOUT_EN
    step(3'b000, 1, 0);
    idle_n(TMO - 1);
    check_val("tmo_still_armed", int'(armed), 1);
    step(3'b000, 0, 0);
    check_val("tmo_pulse", int'(timeout), 1);
    check_val("tmo_disarmed", int'(armed), 0);
    idle_n(2);
    check_val("tmo_single_pulse", tally_tmo, 1);
`else
    step(3'b000, 1, 0);
    idle_n(TMO + 10);
    check_val("no_tmo_armed", int'(armed), 1);
    check_val("no_tmo_pulse", tally_tmo, 0);
    hold_n(3'b100, 10);
    idle_n(25);
`endif

    // Random stimulus against the model
    for (int seg = 0; seg < 400; seg++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: p = 3'b000;
        5, 6, 7:       p = 3'b001 << $urandom_range(0, 2);
        default:       p = 3'($urandom_range(0, 7));
      endcase
      dur = $urandom_range(1, 12);
      for (int i = 0; i < dur; i++) begin
        vok = ($urandom_range(0, 5) == 0);
        step(p, vok, ($urandom_range(0, 399) == 0));
      end
    end
    idle_n(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
